// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle unsigned 32x32 multiply controller.
// While a multiply runs, this block borrows the shared EX-stage ALU and drives
// one shift-add iteration through it per cycle, using the ALU's ADD op. The
// 64-bit product lands in HI/LO, and the pipeline is stalled while the
// multiply is busy. When no multiply is running, the EX-stage operands and op
// pass straight through to the ALU.
module alu_mul_sequencer #(
  parameter int NB_REG       = 32,
  parameter int NB_ALU_CTRLI = 4,
  parameter int NB_COUNT     = 6
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [NB_REG-1:0]       i_op_a,
  input  logic [NB_REG-1:0]       i_op_b,
  input  logic                    i_flush,
  input  logic [NB_REG-1:0]       i_ex_a,
  input  logic [NB_REG-1:0]       i_ex_b,
  input  logic [NB_ALU_CTRLI-1:0] i_ex_alu_op,
  input  logic [NB_REG-1:0]       i_alu_result,
  output logic [NB_REG-1:0]       o_alu_a,
  output logic [NB_REG-1:0]       o_alu_b,
  output logic [NB_ALU_CTRLI-1:0] o_alu_op,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [NB_REG-1:0]       o_hi,
  output logic [NB_REG-1:0]       o_lo
);

  localparam logic [NB_ALU_CTRLI-1:0] OP_ADD   = NB_ALU_CTRLI'(4'h3);
  localparam logic [NB_COUNT-1:0]     LAST_CNT = NB_COUNT'(NB_REG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NB_COUNT-1:0] cnt_q;
  logic [NB_REG-1:0]   mcand_q;
  logic [NB_REG-1:0]   acc_q;
  logic [NB_REG-1:0]   mul_q;
  logic [NB_REG-1:0]   hi_q;
  logic [NB_REG-1:0]   lo_q;
  logic                busy_q;
  logic                done_q;

  logic                carry;
  logic [NB_REG-1:0]   acc_shift;
  logic [NB_REG-1:0]   mul_shift;
  logic                accept;

  // The ALU has no carry output, so the carry out of acc + addend is
  // recovered by an unsigned wrap test: the sum is smaller than acc only
  // if the addition overflowed.
  function automatic logic add_carry(input logic [NB_REG-1:0] sum,
                                     input logic [NB_REG-1:0] base);
    return (sum < base);
  endfunction

  assign carry     = add_carry(i_alu_result, acc_q);
  // {acc,mul} <= {carry,sum,mul} >> 1
  assign acc_shift = {carry, i_alu_result[NB_REG-1:1]};
  assign mul_shift = {i_alu_result[0], mul_q[NB_REG-1:1]};

  // A start is honoured only outside RUN, and a flush always beats it.
  assign accept    = i_start && !i_flush && (state_q != RUN);

  // Next-state decode and ALU operand mux
  always_comb begin
    state_d  = state_q;
    o_alu_a  = i_ex_a;
    o_alu_b  = i_ex_b;
    o_alu_op = i_ex_alu_op;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        o_alu_a  = acc_q;
        o_alu_b  = mul_q[0] ? mcand_q : '0;
        o_alu_op = OP_ADD;
        if (i_flush)                state_d = IDLE;
        else if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        state_d = accept ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, iteration datapath and HI/LO registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      mul_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      if (accept) begin
        mcand_q <= i_op_a;
        acc_q   <= '0;
        mul_q   <= i_op_b;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        acc_q   <= acc_shift;
        mul_q   <= mul_shift;
        cnt_q   <= cnt_q + NB_COUNT'(1);
      end
      // HI/LO take the product from the final iteration's shifted result.
      if ((state_q == RUN) && (state_d == DONE)) begin
        hi_q    <= acc_shift;
        lo_q    <= mul_shift;
      end
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: self-checking bench for alu_mul_sequencer with a
// behavioural ALU and a scoreboard of expected 64-bit products.
module tb_alu_mul_sequencer;

  localparam int NB_REG       = 32;
  localparam int NB_ALU_CTRLI = 4;
  localparam int NB_COUNT     = 6;

  logic                    i_clock = 1'b0;
  logic                    i_reset;
  logic                    i_start;
  logic [NB_REG-1:0]       i_op_a;
  logic [NB_REG-1:0]       i_op_b;
  logic                    i_flush;
  logic [NB_REG-1:0]       i_ex_a;
  logic [NB_REG-1:0]       i_ex_b;
  logic [NB_ALU_CTRLI-1:0] i_ex_alu_op;
  logic [NB_REG-1:0]       i_alu_result;
  logic [NB_REG-1:0]       o_alu_a;
  logic [NB_REG-1:0]       o_alu_b;
  logic [NB_ALU_CTRLI-1:0] o_alu_op;
  logic                    o_busy;
  logic                    o_done;
  logic [NB_REG-1:0]       o_hi;
  logic [NB_REG-1:0]       o_lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb[$];

  alu_mul_sequencer #(
    .NB_REG      (NB_REG),
    .NB_ALU_CTRLI(NB_ALU_CTRLI),
    .NB_COUNT    (NB_COUNT)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_op_a      (i_op_a),
    .i_op_b      (i_op_b),
    .i_flush     (i_flush),
    .i_ex_a      (i_ex_a),
    .i_ex_b      (i_ex_b),
    .i_ex_alu_op (i_ex_alu_op),
    .i_alu_result(i_alu_result),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_op    (o_alu_op),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_hi        (o_hi),
    .o_lo        (o_lo)
  );

  always #5 i_clock = ~i_clock;

  // Shared ALU model: ADD for op 3, SUB otherwise.
  always_comb begin
    if (o_alu_op == 4'h3) i_alu_result = o_alu_a + o_alu_b;
    else                  i_alu_result = o_alu_a - o_alu_b;
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Issues one multiply from the current cycle and follows it to its o_done
  // cycle, where it returns. junk_at > 0 raises i_start with other operands
  // during that RUN cycle, which must be ignored.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int junk_at);
    logic [63:0] exp;
    int          lat;
    int          busy_cnt;
    int          bad_op;
    i_op_a  = a;
    i_op_b  = b;
    i_start = 1'b1;
    sb.push_back(64'(a) * 64'(b));
    tick();
    i_start  = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    bad_op   = 0;
    checks++;
    if (o_alu_a !== 32'd0 || o_alu_b !== (b[0] ? a : 32'd0)) begin
      errors++;
      $display("FAIL first_iter: alu_a=%h alu_b=%h, required alu_a=0 alu_b=%h",
               o_alu_a, o_alu_b, (b[0] ? a : 32'd0));
    end
    while (o_done !== 1'b1 && lat < 40) begin
      if (o_busy === 1'b1) begin
        busy_cnt++;
        if (o_alu_op !== 4'h3) bad_op++;
      end
      i_start = (lat == junk_at);
      if (lat == junk_at) begin
        i_op_a = ~a;
        i_op_b = b + 32'd1;
      end
      tick();
      lat++;
    end
    i_start = 1'b0;
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL latency: done after %0d cycles, required 33", lat);
    end
    checks++;
    if (busy_cnt != 32) begin
      errors++;
      $display("FAIL busy_cycles: %0d, required 32", busy_cnt);
    end
    checks++;
    if (bad_op != 0) begin
      errors++;
      $display("FAIL run_alu_op: %0d RUN cycles without op 3, required 0", bad_op);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_done: %b, required 0", o_busy);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected product queued");
    end else begin
      exp = sb.pop_front();
      if ({o_hi, o_lo} !== exp) begin
        errors++;
        $display("FAIL product %h x %h: hi=%h lo=%h, required hi=%h lo=%h",
                 a, b, o_hi, o_lo, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_reset();
    i_reset     = 1'b0;
    i_start     = 1'b0;
    i_flush     = 1'b0;
    i_op_a      = '0;
    i_op_b      = '0;
    i_ex_a      = 32'h1111_2222;
    i_ex_b      = 32'h3333_4444;
    i_ex_alu_op = 4'h6;
    #3;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_hi !== 32'd0 || o_lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b hi=%h lo=%h, required all 0",
               o_busy, o_done, o_hi, o_lo);
    end
    checks++;
    if (o_alu_a !== i_ex_a || o_alu_b !== i_ex_b || o_alu_op !== 4'h6) begin
      errors++;
      $display("FAIL reset_mux: a=%h b=%h op=%h, required %h %h 6",
               o_alu_a, o_alu_b, o_alu_op, i_ex_a, i_ex_b);
    end
    tick();
    tick();
    i_reset = 1'b1;
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b done=%b, required 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_passthrough();
    i_ex_a      = 32'd7;
    i_ex_b      = 32'd2;
    i_ex_alu_op = 4'h4;
    #1;
    checks++;
    if (o_alu_a !== 32'd7 || o_alu_b !== 32'd2 || o_alu_op !== 4'h4) begin
      errors++;
      $display("FAIL idle_passthrough: a=%h b=%h op=%h, required 7 2 4",
               o_alu_a, o_alu_b, o_alu_op);
    end
    run_mul(32'd3, 32'd5, 0);
    checks++;
    if (o_done !== 1'b1 || o_hi !== 32'd0 || o_lo !== 32'd15) begin
      errors++;
      $display("FAIL mul_3x5: done=%b hi=%h lo=%h, required 1 0 f", o_done, o_hi, o_lo);
    end
    checks++;
    if (o_alu_a !== 32'd7 || o_alu_b !== 32'd2 || o_alu_op !== 4'h4) begin
      errors++;
      $display("FAIL done_passthrough: a=%h b=%h op=%h, required 7 2 4",
               o_alu_a, o_alu_b, o_alu_op);
    end
    tick();
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b one cycle later, required 0", o_done);
    end
  endtask

  task automatic test_products();
    logic [31:0] va[6];
    logic [31:0] vb[6];
    va = '{32'hFFFF_FFFF, 32'd0,      32'h8000_0000, 32'h0001_0000, 32'h0, 32'h0};
    vb = '{32'hFFFF_FFFF, 32'h1234,   32'd2,         32'h0001_0000, 32'h0, 32'h0};
    va[4] = $urandom; vb[4] = $urandom;
    va[5] = $urandom; vb[5] = $urandom;
    for (int i = 0; i < 6; i++) begin
      run_mul(va[i], vb[i], 0);
      tick();
    end
  endtask

  task automatic test_start_ignored();
    run_mul(32'd2, 32'd3, 5);
    tick();
    repeat (3) tick();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_lo !== 32'd6) begin
      errors++;
      $display("FAIL start_in_run_ignored: busy=%b done=%b lo=%h, required 0 0 6",
               o_busy, o_done, o_lo);
    end
  endtask

  task automatic test_back_to_back();
    run_mul(32'd11, 32'd13, 0);
    run_mul(32'hDEAD_BEEF, 32'h1234_5678, 0);
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b done=%b, required 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_flush();
    int done_seen;
    run_mul(32'd6, 32'd7, 0);
    tick();
    i_op_a  = 32'd9;
    i_op_b  = 32'd9;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (9) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_run: busy=%b done=%b, required 0 0", o_busy, o_done);
    end
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_done === 1'b1 || o_busy === 1'b1) done_seen++;
      tick();
    end
    checks++;
    if (done_seen != 0 || o_hi !== 32'd0 || o_lo !== 32'd42) begin
      errors++;
      $display("FAIL flush_retain: activity=%0d hi=%h lo=%h, required 0 0 2a",
               done_seen, o_hi, o_lo);
    end
    i_start = 1'b1;
    i_flush = 1'b1;
    tick();
    i_start = 1'b0;
    i_flush = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_beats_start: busy=%b, required 0", o_busy);
    end
  endtask

  task automatic test_async_reset();
    i_op_a  = 32'd5;
    i_op_b  = 32'd5;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (4) tick();
    #2;
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_hi !== 32'd0 || o_lo !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, required all 0",
               o_busy, o_done, o_hi, o_lo);
    end
    tick();
    i_reset = 1'b1;
    tick();
    run_mul(32'h0000_FFFF, 32'h0001_0001, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_products();
    test_start_ignored();
    test_back_to_back();
    test_flush();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
